axi4_ram_test_wrapper: RTL and testbench
========================================

// Module: axi4_ram_test_wrapper
// PURPOSE
//  Self-contained test top for the AXI4 RAM slave. It has two parts:
//  - an AXI4 master verification agent, axi_vip_0, instanced inside AXI4_RAM_test_i;
//  - a synthesizable AXI4 RAM slave, connected point-to-point to that agent.
//  Benches drive traffic through UUT.AXI4_RAM_test_i.axi_vip_0.inst.IF.
//  Only clock and reset cross the boundary. The RTL in this file is the RAM slave plus the hookup.
// PARAMETERS
//  DATA_WIDTH  64    AXI data bus width in bits; 8 byte lanes
//  ADDR_WIDTH  32    AXI byte-address width
//  ID_WIDTH    4     AWID/ARID/BID/RID width
//  MEM_BYTES   4096  RAM size in bytes; 512 words of 64 bits
// PORTS
//  aclk_0     in  1  single clock for agent and RAM; bench runs it at 4 ns period
//  aresetn_0  in  1  reset, asynchronous, active-low
//  (internal)        full AXI4 AW/W/B/AR/R bundle between axi_vip_0 and the RAM; no user/region logic
// BEHAVIOUR
//  Reset outputs:
//  - On reset, all slave outputs are driven low: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST.
//  - BRESP/RRESP reset to OKAY (2'b00). Both FSMs reset to IDLE.
//  - RAM contents are not cleared by reset; simulation init is 0.
//  - Reset asserted mid-burst aborts the burst immediately. No BVALID/RVALID is issued for it.
//  Channel independence:
//  - The read and write FSMs are fully independent and may run concurrently.
//  - On a same-cycle read and write to the same word, the read returns the old data.
//  Write FSM:
//  - IDLE: AWREADY=1. On the AW handshake, latch AWID, AWADDR, AWLEN, AWSIZE, AWBURST, then go to WDATA.
//  - WDATA: WREADY=1. On each W handshake, write the byte lanes enabled by WSTRB at the current word.
//    The word index is addr[11:3]. Then advance the address.
//  - On the W handshake with WLAST=1, go to WRESP. Beats are counted; WLAST is trusted, the count is not checked.
//  - WRESP: BVALID=1, BID=latched AWID, BRESP=OKAY. Hold until BREADY, then return to IDLE.
//  Read FSM:
//  - IDLE: ARREADY=1. On the AR handshake, latch the AR fields, start the memory read, go to RDATA.
//    First RVALID comes 1 cycle after the AR handshake (registered RAM read).
//  - RDATA: present one beat per cycle while RREADY=1. RDATA is the full 64-bit word; RID=ARID; RRESP=OKAY.
//  - RLAST=1 on beat ARLEN. Under backpressure, hold RDATA/RLAST stable while RVALID=1 and RREADY=0.
//  - After the RLAST handshake, return to IDLE.
//  Address update, per beat (step = 1<<SIZE):
//  - INCR: addr += step.
//  - FIXED: addr unchanged.
//  - WRAP: wraps inside the (LEN+1)*step aligned window.
//  - LEN 0..255 (up to 256 beats). SIZE 1..8 bytes.
//  Unaligned start address: the first beat is treated as aligned down to SIZE; later beats are aligned.
//  Narrow transfers:
//  - Data stays on its natural byte lanes, e.g. a 2-byte write at addr 8 uses lanes 0-1.
//  - Writes honour WSTRB. Reads return the full word; the master selects the lanes.
//  Address range: only addr[11:0] decodes; higher bits are ignored, so accesses alias modulo MEM_BYTES.
//  A burst crossing 4 KB wraps to 0.
//  Error handling: no SLVERR/DECERR is ever returned.
//  Throughput: W accepts 1 beat/cycle. R streams 1 beat/cycle after the 1-cycle startup.
// TESTING
//  1. Wide INCR burst:
//     - Write ID0, addr 0, LEN 127, SIZE 8B; 16-bit halfword i holds value i, i=0..511 -> BRESP OKAY.
//     - Read ID1 of the same burst -> 128 beats; halfword i == i; RLAST only on beat 127.
//  2. Narrow 2-byte write:
//     - Write ID2, addr 8, LEN 0, SIZE 2B, data 0x0800, WSTRB 0x03 -> BRESP OKAY.
//     - Read ID3 -> rdata[15:0]==0x0800.
//     - Bytes 10-15 still hold halfwords 5..7 from scenario 1.
//  3. Backpressure:
//     - Read LEN 7 with RREADY toggled every cycle -> RDATA/RLAST stable while stalled; beats in order.
//  4. Reset mid-write:
//     - Assert aresetn_0 during beat 3 of a LEN 7 write -> all VALID/READY low.
//     - Next AW accepted normally.
//     - Earlier words keep their data.
//  5. FIXED and WRAP bursts:
//     - FIXED LEN 3 writes 4 values to addr 0x10 -> read returns the last value.
//     - WRAP LEN 3 SIZE 8B from 0x18 -> beats hit 0x18, 0x00, 0x08, 0x10.
//  6. Concurrent channels:
//     - Write to 0x100 overlapped with a read from 0x200 -> both complete.
//     - IDs are echoed correctly.

Source files
------------

// File: rtl/axi4_ram_test_wrapper_if.sv
// -----------------------------------------------------------------------------
// axi4_ram_test_wrapper_if
// Purpose : AXI4 bundle (AW/W/B/AR/R) that joins the master agent to the RAM
//           slave inside axi4_ram_test_wrapper. There are no user or region
//           signals.
// Modports: master - drives the address and write channels, and the B/R ready signals
//           slave  - drives the ready signals and the B/R response channels
// -----------------------------------------------------------------------------
interface axi4_ram_test_wrapper_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   // write address channel
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awlock;
   logic [3:0]              awcache;
   logic [2:0]              awprot;
   logic [3:0]              awqos;
   logic                    awvalid;
   logic                    awready;
   // write data channel
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   // write response channel
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   // read address channel
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arlock;
   logic [3:0]              arcache;
   logic [2:0]              arprot;
   logic [3:0]              arqos;
   logic                    arvalid;
   logic                    arready;
   // read data channel
   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi4_ram_test_wrapper.sv
// -----------------------------------------------------------------------------
// axi4_ram_test_wrapper
// Purpose : AXI4 RAM slave (4 KB, 64-bit words) for the RAM test top. The
//           master agent connects point-to-point through the s_axi bundle.
//           The read and write channels run as independent FSMs. Writes
//           honour WSTRB. Reads return the full word, and the first beat
//           follows the AR handshake by one cycle. FIXED, INCR and WRAP
//           bursts are supported. Only addr[11:0] is decoded, so addresses
//           alias modulo the RAM size.
// Ports   : aclk_0    - clock
//           aresetn_0 - asynchronous active-low reset (RAM contents are kept)
//           s_axi     - AXI4 slave modport (AW/W/B/AR/R)
// -----------------------------------------------------------------------------
module axi4_ram_test_wrapper #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_BYTES  = 4096
) (
   input  logic                  aclk_0,
   input  logic                  aresetn_0,
   axi4_ram_test_wrapper_if.slave s_axi
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS_W = $clog2(MEM_BYTES);
   localparam int LANE_W = $clog2(STRB_W);
   localparam int WORDS  = MEM_BYTES / STRB_W;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   // Address of the next beat. The current address is first aligned down to
   // the transfer size, so an unaligned start only affects the first beat.
   // For WRAP the window is (len+1)*step bytes, aligned to its own size.
   function automatic logic [OFFS_W-1:0] next_addr(input logic [OFFS_W-1:0] addr,
                                                   input logic [2:0]        size,
                                                   input logic [7:0]        len,
                                                   input logic [1:0]        burst);
      logic [15:0]       step;
      logic [15:0]       aligned;
      logic [15:0]       incr;
      logic [15:0]       wmask;
      logic [15:0]       wrapped;
      logic [OFFS_W-1:0] result;
      step    = 16'd1 << size;
      aligned = 16'(addr) & ~(step - 16'd1);
      incr    = aligned + step;
      wmask   = ((16'(len) + 16'd1) * step) - 16'd1;
      wrapped = (aligned & ~wmask) | (incr & wmask);
      case (burst)
         BURST_FIXED: result = addr;
         BURST_INCR:  result = incr[OFFS_W-1:0];
         BURST_WRAP:  result = wrapped[OFFS_W-1:0];
         default:     result = incr[OFFS_W-1:0];
      endcase
      return result;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [0:WORDS-1];

   logic [1:0]            wstate_q, wstate_d;
   logic [ID_WIDTH-1:0]   awid_q, awid_d;
   logic [OFFS_W-1:0]     waddr_q, waddr_d;
   logic [7:0]            awlen_q, awlen_d;
   logic [2:0]            awsize_q, awsize_d;
   logic [1:0]            awburst_q, awburst_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic                  mem_we_s;

   logic [0:0]            rstate_q, rstate_d;
   logic [ID_WIDTH-1:0]   arid_q, arid_d;
   logic [OFFS_W-1:0]     raddr_q, raddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [2:0]            arsize_q, arsize_d;
   logic [1:0]            arburst_q, arburst_d;
   logic [7:0]            rbeat_q, rbeat_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rlast_q, rlast_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // Sideband fields and address bits above the RAM window are not decoded.
   logic unused_s;
   assign unused_s = ^{s_axi.awaddr[ADDR_WIDTH-1:OFFS_W], s_axi.araddr[ADDR_WIDTH-1:OFFS_W],
                       s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                       s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};

   // Write channel FSM: accept AW, stream W beats into RAM, then issue B.
   always_comb begin
      wstate_d  = wstate_q;
      awid_d    = awid_q;
      waddr_d   = waddr_q;
      awlen_d   = awlen_q;
      awsize_d  = awsize_q;
      awburst_d = awburst_q;
      mem_we_s  = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (s_axi.awvalid && awready_q) begin
               awid_d    = s_axi.awid;
               waddr_d   = s_axi.awaddr[OFFS_W-1:0];
               awlen_d   = s_axi.awlen;
               awsize_d  = s_axi.awsize;
               awburst_d = s_axi.awburst;
               wstate_d  = W_DATA;
            end else begin
               wstate_d  = W_IDLE;
            end
         end
         W_DATA: begin
            if (s_axi.wvalid && wready_q) begin
               mem_we_s = 1'b1;
               waddr_d  = next_addr(waddr_q, awsize_q, awlen_q, awburst_q);
               // WLAST ends the burst; the beat count is not cross-checked.
               if (s_axi.wlast) begin
                  wstate_d = W_RESP;
               end else begin
                  wstate_d = W_DATA;
               end
            end else begin
               wstate_d = W_DATA;
            end
         end
         W_RESP: begin
            if (s_axi.bready && bvalid_q) begin
               wstate_d = W_IDLE;
            end else begin
               wstate_d = W_RESP;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
      awready_d = (wstate_d == W_IDLE);
      wready_d  = (wstate_d == W_DATA);
      bvalid_d  = (wstate_d == W_RESP);
   end

   // Read channel FSM: the AR handshake launches the first RAM read. Each
   // accepted beat fetches the next word, so stalls hold RDATA and RLAST.
   always_comb begin
      rstate_d  = rstate_q;
      arid_d    = arid_q;
      raddr_d   = raddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      rbeat_d   = rbeat_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      case (rstate_q)
         R_IDLE: begin
            if (s_axi.arvalid && arready_q) begin
               arid_d    = s_axi.arid;
               arlen_d   = s_axi.arlen;
               arsize_d  = s_axi.arsize;
               arburst_d = s_axi.arburst;
               rdata_d   = mem_q[s_axi.araddr[OFFS_W-1:LANE_W]];
               raddr_d   = next_addr(s_axi.araddr[OFFS_W-1:0], s_axi.arsize,
                                     s_axi.arlen, s_axi.arburst);
               rbeat_d   = 8'd0;
               rvalid_d  = 1'b1;
               rlast_d   = (s_axi.arlen == 8'd0);
               rstate_d  = R_DATA;
            end else begin
               rstate_d  = R_IDLE;
            end
         end
         R_DATA: begin
            if (rvalid_q && s_axi.rready) begin
               if (rlast_q) begin
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
                  rstate_d = R_IDLE;
               end else begin
                  rdata_d  = mem_q[raddr_q[OFFS_W-1:LANE_W]];
                  raddr_d  = next_addr(raddr_q, arsize_q, arlen_q, arburst_q);
                  rbeat_d  = rbeat_q + 8'd1;
                  rlast_d  = ((rbeat_q + 8'd1) == arlen_q);
                  rstate_d = R_DATA;
               end
            end else begin
               rstate_d = R_DATA;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      arready_d = (rstate_d == R_IDLE);
   end

   // Control and response registers. Reset aborts any burst in flight.
   always_ff @(posedge aclk_0 or negedge aresetn_0) begin
      if (!aresetn_0) begin
         wstate_q  <= W_IDLE;
         awid_q    <= {ID_WIDTH{1'b0}};
         waddr_q   <= {OFFS_W{1'b0}};
         awlen_q   <= 8'd0;
         awsize_q  <= 3'd0;
         awburst_q <= 2'd0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         rstate_q  <= R_IDLE;
         arid_q    <= {ID_WIDTH{1'b0}};
         raddr_q   <= {OFFS_W{1'b0}};
         arlen_q   <= 8'd0;
         arsize_q  <= 3'd0;
         arburst_q <= 2'd0;
         rbeat_q   <= 8'd0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= {DATA_WIDTH{1'b0}};
      end else begin
         wstate_q  <= wstate_d;
         awid_q    <= awid_d;
         waddr_q   <= waddr_d;
         awlen_q   <= awlen_d;
         awsize_q  <= awsize_d;
         awburst_q <= awburst_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         rstate_q  <= rstate_d;
         arid_q    <= arid_d;
         raddr_q   <= raddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         rbeat_q   <= rbeat_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
      end
   end

   // RAM byte-lane writes. The array has no reset, and a read of the same
   // word in the same cycle sees the old data.
   always_ff @(posedge aclk_0) begin
      if (mem_we_s) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi.wstrb[b]) begin
               mem_q[waddr_q[OFFS_W-1:LANE_W]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
         end
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = awid_q;
   assign s_axi.bresp   = RESP_OKAY;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rid     = arid_q;
   assign s_axi.rresp   = RESP_OKAY;
endmodule

// File: tb/tb_axi4_ram_test_wrapper.sv
// -----------------------------------------------------------------------------
// tb_axi4_ram_test_wrapper
// Purpose : directed self-checking bench for axi4_ram_test_wrapper. The bench
//           acts as the AXI master through the interface instance. Inputs are
//           driven on the falling edge, and handshakes happen on the following
//           rising edge.
// -----------------------------------------------------------------------------
module tb_axi4_ram_test_wrapper;
   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   logic aclk_0 = 1'b0;
   logic aresetn_0;
   always #2 aclk_0 = ~aclk_0;

   axi4_ram_test_wrapper_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) axi ();

   axi4_ram_test_wrapper #(
      .DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_BYTES(4096)
   ) dut (
      .aclk_0   (aclk_0),
      .aresetn_0(aresetn_0),
      .s_axi    (axi)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] wr_buf  [0:255];
   logic [7:0]  wr_strb [0:255];
   logic [63:0] rd_buf  [0:255];

   typedef struct {
      logic [31:0] wr_addr;
      logic [31:0] rd_addr;
      logic [2:0]  size;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs [0:7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Scenario 1 fill: 16-bit halfword i holds value i.
   function automatic logic [63:0] s1_word(input int w);
      return {16'(4*w+3), 16'(4*w+2), 16'(4*w+1), 16'(4*w)};
   endfunction

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int cnt;
      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
      axi.awburst = burst; axi.awvalid = 1'b1;
      cnt = 0;
      while (!axi.awready && cnt < 100) begin @(negedge aclk_0); cnt++; end
      check("aw_ready", 64'(axi.awready), 64'd1);
      @(negedge aclk_0);
      axi.awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int cnt;
      axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
      cnt = 0;
      while (!axi.wready && cnt < 100) begin @(negedge aclk_0); cnt++; end
      check("w_ready", 64'(axi.wready), 64'd1);
      @(negedge aclk_0);
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
      int cnt;
      aw_send(id, addr, len, size, burst);
      for (int i = 0; i <= int'(len); i++) w_beat(wr_buf[i], wr_strb[i], i == int'(len));
      axi.bready = 1'b1;
      cnt = 0;
      while (!axi.bvalid && cnt < 100) begin @(negedge aclk_0); cnt++; end
      check("b_valid", 64'(axi.bvalid), 64'd1);
      check("b_id", 64'(axi.bid), 64'(id));
      check("b_resp", 64'(axi.bresp), 64'd0);
      @(negedge aclk_0);
      axi.bready = 1'b0;
      check("b_done", 64'(axi.bvalid), 64'd0);
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
      int cnt;
      int beat;
      bit stalled;
      logic [63:0] hd;
      logic hl;
      axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
      axi.arburst = burst; axi.arvalid = 1'b1;
      cnt = 0;
      while (!axi.arready && cnt < 100) begin @(negedge aclk_0); cnt++; end
      check("ar_ready", 64'(axi.arready), 64'd1);
      @(negedge aclk_0);
      axi.arvalid = 1'b0;
      check("r_first_latency", 64'(axi.rvalid), 64'd1);
      beat = 0; cnt = 0; stalled = 1'b0; hd = 64'd0; hl = 1'b0;
      axi.rready = 1'b0;
      while (beat <= int'(len) && cnt < 2000) begin
         axi.rready = toggle ? !axi.rready : 1'b1;
         if (axi.rvalid) begin
            if (stalled) begin
               check("r_hold_data", axi.rdata, hd);
               check("r_hold_last", 64'(axi.rlast), 64'(hl));
            end
            if (axi.rready) begin
               rd_buf[beat] = axi.rdata;
               check("r_id", 64'(axi.rid), 64'(id));
               check("r_resp", 64'(axi.rresp), 64'd0);
               check("r_last", 64'(axi.rlast), 64'(beat == int'(len)));
               beat++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               hd = axi.rdata;
               hl = axi.rlast;
            end
         end
         @(negedge aclk_0);
         cnt++;
      end
      axi.rready = 1'b0;
      check("r_beats", 64'(beat), 64'(int'(len) + 1));
      check("r_done", 64'(axi.rvalid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.awid = 4'd0; axi.awaddr = 32'd0; axi.awlen = 8'd0; axi.awsize = 3'd0;
      axi.awburst = 2'd0; axi.awlock = 1'b0; axi.awcache = 4'd0; axi.awprot = 3'd0;
      axi.awqos = 4'd0; axi.awvalid = 1'b0;
      axi.wdata = 64'd0; axi.wstrb = 8'd0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
      axi.bready = 1'b0;
      axi.arid = 4'd0; axi.araddr = 32'd0; axi.arlen = 8'd0; axi.arsize = 3'd0;
      axi.arburst = 2'd0; axi.arlock = 1'b0; axi.arcache = 4'd0; axi.arprot = 3'd0;
      axi.arqos = 4'd0; axi.arvalid = 1'b0;
      axi.rready = 1'b0;

      // narrow/aliasing table: single-beat write, then single-beat read of the full word
      vecs[0] = '{32'h0000_0008, 32'h0000_0008, 3'd1, 64'h0000_0000_0000_0800, 8'h03, 64'h0007_0006_0005_0800};
      vecs[1] = '{32'h0000_0800, 32'h0000_0800, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788};
      vecs[2] = '{32'h0000_0802, 32'h0000_0800, 3'd1, 64'h0000_0000_ABCD_0000, 8'h0C, 64'h1122_3344_ABCD_7788};
      vecs[3] = '{32'h0000_0807, 32'h0000_0800, 3'd0, 64'hEE00_0000_0000_0000, 8'h80, 64'hEE22_3344_ABCD_7788};
      vecs[4] = '{32'h0000_0804, 32'h0000_0800, 3'd2, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'hDEAD_BEEF_ABCD_7788};
      vecs[5] = '{32'h0001_0800, 32'h0000_0800, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'hDEAD_BEEF_ABCD_7788};
      vecs[6] = '{32'hFFFF_F808, 32'h0000_0808, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF};
      vecs[7] = '{32'h0000_0808, 32'h7000_1808, 3'd0, 64'h0000_0000_0000_0055, 8'h01, 64'h0123_4567_89AB_CD55};

      // reset state
      aresetn_0 = 1'b0;
      repeat (3) @(negedge aclk_0);
      check("rst_awready", 64'(axi.awready), 64'd0);
      check("rst_wready",  64'(axi.wready),  64'd0);
      check("rst_bvalid",  64'(axi.bvalid),  64'd0);
      check("rst_arready", 64'(axi.arready), 64'd0);
      check("rst_rvalid",  64'(axi.rvalid),  64'd0);
      check("rst_rlast",   64'(axi.rlast),   64'd0);
      check("rst_bresp",   64'(axi.bresp),   64'd0);
      check("rst_rresp",   64'(axi.rresp),   64'd0);
      aresetn_0 = 1'b1;
      @(negedge aclk_0);
      check("idle_awready", 64'(axi.awready), 64'd1);
      check("idle_arready", 64'(axi.arready), 64'd1);

      // 1: wide INCR burst of 128 beats
      for (int i = 0; i < 128; i++) begin wr_buf[i] = s1_word(i); wr_strb[i] = 8'hFF; end
      axi_write(4'd0, 32'h0, 8'd127, 3'd3, INCR);
      axi_read(4'd1, 32'h0, 8'd127, 3'd3, INCR, 1'b0);
      for (int i = 0; i < 128; i++) check("s1_data", rd_buf[i], s1_word(i));

      // 2: narrow and aliasing table
      for (int v = 0; v < 8; v++) begin
         wr_buf[0] = vecs[v].wdata; wr_strb[0] = vecs[v].wstrb;
         axi_write(4'd2, vecs[v].wr_addr, 8'd0, vecs[v].size, INCR);
         axi_read(4'd3, vecs[v].rd_addr, 8'd0, vecs[v].size, INCR, 1'b0);
         check("vec_data", rd_buf[0], vecs[v].exp);
      end

      // 3: read under RREADY backpressure
      axi_read(4'd6, 32'h20, 8'd7, 3'd3, INCR, 1'b1);
      for (int i = 0; i < 8; i++) check("bp_data", rd_buf[i], s1_word(4 + i));

      // 4: reset during beat 3 of a LEN 7 write
      aw_send(4'd5, 32'h300, 8'd7, 3'd3, INCR);
      for (int i = 0; i < 3; i++) w_beat(64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF, 1'b0);
      axi.wdata = 64'hA5A5_0000_0000_0003; axi.wstrb = 8'hFF; axi.wvalid = 1'b1;
      #1 aresetn_0 = 1'b0;
      #1;
      check("mid_rst_awready", 64'(axi.awready), 64'd0);
      check("mid_rst_wready",  64'(axi.wready),  64'd0);
      check("mid_rst_bvalid",  64'(axi.bvalid),  64'd0);
      check("mid_rst_arready", 64'(axi.arready), 64'd0);
      check("mid_rst_rvalid",  64'(axi.rvalid),  64'd0);
      axi.wvalid = 1'b0;
      @(negedge aclk_0);
      check("mid_rst_no_bvalid", 64'(axi.bvalid), 64'd0);
      aresetn_0 = 1'b1;
      @(negedge aclk_0);
      wr_buf[0] = 64'h5A5A_0000_0000_0003; wr_strb[0] = 8'hFF;
      axi_write(4'd9, 32'h318, 8'd0, 3'd3, INCR);
      axi_read(4'd10, 32'h300, 8'd3, 3'd3, INCR, 1'b0);
      check("rst_w0", rd_buf[0], 64'hA5A5_0000_0000_0000);
      check("rst_w1", rd_buf[1], 64'hA5A5_0000_0000_0001);
      check("rst_w2", rd_buf[2], 64'hA5A5_0000_0000_0002);
      check("rst_w3", rd_buf[3], 64'h5A5A_0000_0000_0003);
      axi_read(4'd11, 32'h20, 8'd0, 3'd3, INCR, 1'b0);
      check("rst_keep", rd_buf[0], s1_word(4));

      // 5: FIXED, WRAP and 4 KB crossing
      for (int i = 0; i < 4; i++) begin wr_buf[i] = 64'hF1F1_0000_0000_0000 | 64'(i); wr_strb[i] = 8'hFF; end
      axi_write(4'd12, 32'h10, 8'd3, 3'd3, FIXED);
      axi_read(4'd13, 32'h10, 8'd0, 3'd3, INCR, 1'b0);
      check("fixed_last", rd_buf[0], 64'hF1F1_0000_0000_0003);
      axi_read(4'd13, 32'h18, 8'd0, 3'd3, INCR, 1'b0);
      check("fixed_neighbour", rd_buf[0], s1_word(3));
      for (int i = 0; i < 4; i++) wr_buf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
      axi_write(4'd14, 32'h18, 8'd3, 3'd3, WRAP);
      axi_read(4'd15, 32'h0, 8'd3, 3'd3, INCR, 1'b0);
      check("wrap_0x00", rd_buf[0], 64'hC0DE_0000_0000_0001);
      check("wrap_0x08", rd_buf[1], 64'hC0DE_0000_0000_0002);
      check("wrap_0x10", rd_buf[2], 64'hC0DE_0000_0000_0003);
      check("wrap_0x18", rd_buf[3], 64'hC0DE_0000_0000_0000);
      axi_read(4'd1, 32'h18, 8'd3, 3'd3, WRAP, 1'b0);
      for (int i = 0; i < 4; i++) check("wrap_read", rd_buf[i], 64'hC0DE_0000_0000_0000 | 64'(i));
      wr_buf[0] = 64'h4444_0000_0000_0FF8; wr_buf[1] = 64'h4444_0000_0000_0000;
      axi_write(4'd4, 32'hFF8, 8'd1, 3'd3, INCR);
      axi_read(4'd4, 32'h0, 8'd0, 3'd3, INCR, 1'b0);
      check("cross_4k", rd_buf[0], 64'h4444_0000_0000_0000);

      // 6: overlapped write and read
      for (int i = 0; i < 4; i++) begin wr_buf[i] = 64'hBEEF_0000_0000_0000 | 64'(i); wr_strb[i] = 8'hFF; end
      fork
         axi_write(4'd7, 32'h100, 8'd3, 3'd3, INCR);
         axi_read(4'd8, 32'h200, 8'd3, 3'd3, INCR, 1'b0);
      join
      for (int i = 0; i < 4; i++) check("conc_read", rd_buf[i], s1_word(64 + i));
      axi_read(4'd9, 32'h100, 8'd3, 3'd3, INCR, 1'b0);
      for (int i = 0; i < 4; i++) check("conc_write", rd_buf[i], 64'hBEEF_0000_0000_0000 | 64'(i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
